// File: rtl/reset_sequencer.sv
// reset_sequencer: power-on / push-button reset sequencer on the x4 clock.
// Optional watchdog enabled by defining RESET_SEQ_WATCHDOG_EN.
module reset_sequencer #(
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = 1024,
    parameter int HOLD_CYCLES       = 64,
    parameter int DIV_SETTLE_CYCLES = 16,
    parameter int CNT_WIDTH         = 16,
    parameter int WATCHDOG_CYCLES   = 65536
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button,
    input  logic       wdKick,
    output logic       divRstN,
    output logic       coreRstN,
    output logic       busy,
    output logic [7:0] resetCount,
    output logic       wdFired
);

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        DIV_RUN = 2'd1,
        RUN     = 2'd2
    } seqStateT;

    // Terminal values: a counter sitting at *_LAST completes on the next edge.
    localparam logic [CNT_WIDTH-1:0] DB_LAST =
        CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST =
        CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] SET_LAST =
        CNT_WIDTH'(DIV_SETTLE_CYCLES - 1);

    seqStateT             state;
    logic [SYNC_STAGES-1:0] syncQ;
    logic                 btnSync;
    logic [CNT_WIDTH-1:0] dbCnt;
    logic                 debounced;
    logic                 dbPrev;
    logic                 dbRise;
    logic [CNT_WIDTH-1:0] holdCnt;
    logic [CNT_WIDTH-1:0] setCnt;
    logic                 wdExpire;

    assign btnSync = syncQ[SYNC_STAGES-1];
    assign dbRise  = debounced & ~dbPrev;
    assign busy    = (state != RUN);

    // Bring the asynchronous button into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            syncQ <= '0;
        end else begin
            syncQ <= {syncQ[SYNC_STAGES-2:0], button};
        end
    end

    // Accept a new button level only after it has been stable long enough.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbCnt     <= '0;
            debounced <= 1'b0;
        end else if (btnSync != debounced) begin
            if (dbCnt == DB_LAST) begin
                debounced <= btnSync;
                dbCnt     <= '0;
            end else begin
                dbCnt <= dbCnt + 1'b1;
            end
        end else begin
            dbCnt <= '0;
        end
    end

    // Delayed copy of the debounced level for press edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbPrev <= 1'b0;
        end else begin
            dbPrev <= debounced;
        end
    end

`ifdef RESET_SEQ_WATCHDOG_EN
    localparam int WD_WIDTH = $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [WD_WIDTH-1:0] WD_LAST =
        WD_WIDTH'(WATCHDOG_CYCLES - 1);

    logic [WD_WIDTH-1:0] wdCnt;
    logic                wdFiredQ;

    // A kick on the terminal edge still saves the system.
    assign wdExpire = (state == RUN) && !wdKick && (wdCnt == WD_LAST);
    assign wdFired  = wdFiredQ;

    // Watchdog counts only in RUN; a button press pre-empts a timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdCnt    <= '0;
            wdFiredQ <= 1'b0;
        end else begin
            if (state != RUN || dbRise || wdKick || wdExpire) begin
                wdCnt <= '0;
            end else begin
                wdCnt <= wdCnt + 1'b1;
            end
            if (wdExpire && !dbRise) begin
                wdFiredQ <= 1'b1;
            end
        end
    end
`else
    localparam int unusedWdCycles = WATCHDOG_CYCLES;
    logic unusedWdKick;

    assign unusedWdKick = wdKick;
    assign wdExpire     = 1'b0;
    assign wdFired      = 1'b0;
`endif

    // Sequencer: hold both resets, free the divider, then free the core.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= HOLD;
            holdCnt    <= '0;
            setCnt     <= '0;
            divRstN    <= 1'b0;
            coreRstN   <= 1'b0;
            resetCount <= 8'd0;
        end else if (dbRise) begin
            state    <= HOLD;
            holdCnt  <= '0;
            setCnt   <= '0;
            divRstN  <= 1'b0;
            coreRstN <= 1'b0;
            if (resetCount != 8'hFF) begin
                resetCount <= resetCount + 8'd1;
            end
        end else if (wdExpire) begin
            state    <= HOLD;
            holdCnt  <= '0;
            setCnt   <= '0;
            divRstN  <= 1'b0;
            coreRstN <= 1'b0;
        end else begin
            unique case (state)
                HOLD: begin
                    divRstN  <= 1'b0;
                    coreRstN <= 1'b0;
                    setCnt   <= '0;
                    if (debounced) begin
                        holdCnt <= '0;
                    end else if (holdCnt == HOLD_LAST) begin
                        holdCnt <= '0;
                        state   <= DIV_RUN;
                        divRstN <= 1'b1;
                    end else begin
                        holdCnt <= holdCnt + 1'b1;
                    end
                end
                DIV_RUN: begin
                    divRstN  <= 1'b1;
                    coreRstN <= 1'b0;
                    holdCnt  <= '0;
                    if (setCnt == SET_LAST) begin
                        setCnt   <= '0;
                        state    <= RUN;
                        coreRstN <= 1'b1;
                    end else begin
                        setCnt <= setCnt + 1'b1;
                    end
                end
                RUN: begin
                    divRstN  <= 1'b1;
                    coreRstN <= 1'b1;
                    holdCnt  <= '0;
                    setCnt   <= '0;
                end
                default: begin
                    state    <= HOLD;
                    holdCnt  <= '0;
                    setCnt   <= '0;
                    divRstN  <= 1'b0;
                    coreRstN <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: random and directed stimulus against an
// age-based behavioural model of the reset sequence.
module tb_reset_sequencer;

    localparam int SYNC   = 2;
    localparam int DB     = 4;
    localparam int HOLD   = 8;
    localparam int SETTLE = 16;
    localparam int WD     = 32;
    localparam int RUNAGE = HOLD + SETTLE;
`ifdef RESET_SEQ_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       button;
    logic       wdKick;
    logic       divRstN;
    logic       coreRstN;
    logic       busy;
    logic [7:0] resetCount;
    logic       wdFired;

    int nTests = 0;
    int nFail  = 0;
    bit armed  = 1'b0;

    reset_sequencer #(
        .SYNC_STAGES(SYNC),
        .DEBOUNCE_CYCLES(DB),
        .HOLD_CYCLES(HOLD),
        .DIV_SETTLE_CYCLES(SETTLE),
        .CNT_WIDTH(16),
        .WATCHDOG_CYCLES(WD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .button(button),
        .wdKick(wdKick),
        .divRstN(divRstN),
        .coreRstN(coreRstN),
        .busy(busy),
        .resetCount(resetCount),
        .wdFired(wdFired)
    );

    always #5 clk = ~clk;

    // Model: one "age" number = edges since the sequence began counting.
    // age >= HOLD means divider free, age >= HOLD+SETTLE means core free.
    int mAge;
    int mCnt;
    int mWd;
    int mRun;
    bit mDeb;
    bit mBtn;
    bit mPend;
    bit mFired;
    bit mPipe[$];

    function automatic void modelReset();
        mAge   = 0;
        mCnt   = 0;
        mWd    = 0;
        mRun   = 0;
        mDeb   = 0;
        mBtn   = 0;
        mPend  = 0;
        mFired = 0;
        mPipe.delete();
        for (int i = 0; i < SYNC - 1; i++) mPipe.push_back(1'b0);
    endfunction

    always @(posedge clk or posedge rst) begin
        bit oldDeb;
        if (rst) begin
            modelReset();
        end else begin
            oldDeb = mDeb;
            if (mPend) begin
                mAge = 0;
                mWd  = 0;
                if (mCnt < 255) mCnt = mCnt + 1;
            end else if (WD_EN && mAge >= RUNAGE && !wdKick
                         && mWd + 1 == WD) begin
                mFired = 1;
                mAge   = 0;
                mWd    = 0;
            end else begin
                if (mAge >= RUNAGE) mWd = wdKick ? 0 : mWd + 1;
                else mWd = 0;
                if (mAge >= HOLD) begin
                    if (mAge < RUNAGE) mAge = mAge + 1;
                end else if (!mDeb) begin
                    mAge = mAge + 1;
                end
            end
            if (mBtn != mDeb) begin
                mRun = mRun + 1;
                if (mRun == DB) begin
                    mDeb = mBtn;
                    mRun = 0;
                end
            end else begin
                mRun = 0;
            end
            mPipe.push_back(button);
            mBtn  = mPipe.pop_front();
            mPend = mDeb && !oldDeb;
        end
    end

    function automatic void chk(string name, int act, int exp);
        nTests = nTests + 1;
        if (act != exp) begin
            nFail = nFail + 1;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endfunction

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (armed) begin
            chk("divRstN", int'(divRstN), int'(mAge >= HOLD));
            chk("coreRstN", int'(coreRstN), int'(mAge >= RUNAGE));
            chk("busy", int'(busy), int'(mAge < RUNAGE));
            chk("resetCount", int'(resetCount), mCnt);
            chk("wdFired", int'(wdFired), int'(mFired));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic asyncRst();
        #2 rst = 1'b1;
        #1;
        chk("async divRstN", int'(divRstN), 0);
        chk("async coreRstN", int'(coreRstN), 0);
        chk("async resetCount", int'(resetCount), 0);
        chk("async busy", int'(busy), 1);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        modelReset();
        rst    = 1'b1;
        button = 1'b0;
        wdKick = 1'b1;
        @(posedge clk);
        armed = 1'b1;
        @(negedge clk);
        cyc(2);
        rst = 1'b0;

        // Power-on sequence: divider at edge 8, core at edge 24.
        cyc(7);
        chk("po div e7", int'(divRstN), 0);
        cyc(1);
        chk("po div e8", int'(divRstN), 1);
        chk("po core e8", int'(coreRstN), 0);
        cyc(15);
        chk("po core e23", int'(coreRstN), 0);
        chk("po busy e23", int'(busy), 1);
        cyc(1);
        chk("po core e24", int'(coreRstN), 1);
        chk("po busy e24", int'(busy), 0);
        chk("po count", int'(resetCount), 0);

        // Short glitch is filtered.
        button = 1'b1;
        cyc(3);
        button = 1'b0;
        cyc(12);
        chk("glitch count", int'(resetCount), 0);
        chk("glitch core", int'(coreRstN), 1);
        chk("glitch div", int'(divRstN), 1);

        // Debounced press: resets drop 7 edges after edge k.
        button = 1'b1;
        cyc(6);
        chk("press div k+6", int'(divRstN), 1);
        cyc(1);
        chk("press div k+7", int'(divRstN), 0);
        chk("press core k+7", int'(coreRstN), 0);
        chk("press count", int'(resetCount), 1);
        cyc(3);
        button = 1'b0;
        cyc(13);
        chk("rel div k+23", int'(divRstN), 0);
        cyc(1);
        chk("rel div k+24", int'(divRstN), 1);
        cyc(15);
        chk("rel core k+39", int'(coreRstN), 0);
        cyc(1);
        chk("rel core k+40", int'(coreRstN), 1);

        // Second press, then rst in the middle of DIV_RUN.
        button = 1'b1;
        cyc(10);
        button = 1'b0;
        cyc(14);
        chk("mid div", int'(divRstN), 1);
        chk("mid core", int'(coreRstN), 0);
        cyc(3);
        asyncRst();
        cyc(7);
        chk("restart div e7", int'(divRstN), 0);
        cyc(1);
        chk("restart div e8", int'(divRstN), 1);
        cyc(16);
        chk("restart core e24", int'(coreRstN), 1);

        // Random button activity, sparse kicks, occasional rst.
        for (int seg = 0; seg < 250; seg++) begin
            int len;
            button = ~button;
            len    = $urandom_range(1, 14);
            for (int c = 0; c < len; c++) begin
                wdKick = ($urandom_range(0, 15) == 0);
                cyc(1);
            end
            if ($urandom_range(0, 49) == 0) asyncRst();
        end
        button = 1'b0;
        wdKick = 1'b1;
        cyc(40);

        // Many presses saturate the counter.
        for (int p = 0; p < 300; p++) begin
            button = 1'b1;
            cyc(7);
            button = 1'b0;
            cyc(7);
        end
        chk("saturated count", int'(resetCount), 255);
        cyc(40);
        chk("post-sat core", int'(coreRstN), 1);

`ifdef RESET_SEQ_WATCHDOG_EN
        // Starved watchdog fires after 32 RUN edges.
        asyncRst();
        cyc(24);
        chk("wd run", int'(coreRstN), 1);
        wdKick = 1'b0;
        cyc(31);
        chk("wd e31 fired", int'(wdFired), 0);
        chk("wd e31 core", int'(coreRstN), 1);
        cyc(1);
        chk("wd e32 fired", int'(wdFired), 1);
        chk("wd e32 div", int'(divRstN), 0);
        chk("wd e32 core", int'(coreRstN), 0);
        chk("wd count", int'(resetCount), 0);
        cyc(30);
        chk("wd sticky", int'(wdFired), 1);

        // Kicking every 20 edges keeps it quiet.
        asyncRst();
        wdKick = 1'b0;
        cyc(24);
        for (int r = 0; r < 5; r++) begin
            cyc(19);
            wdKick = 1'b1;
            cyc(1);
            wdKick = 1'b0;
        end
        chk("kicked fired", int'(wdFired), 0);
        chk("kicked core", int'(coreRstN), 1);
        wdKick = 1'b1;
`endif

        cyc(5);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Power-on and push-button reset sequencer on the fast (×4) clock, upstream of the clock divider and core.
- Generates the divider's active-low reset first. After a settle window it releases the core's active-low reset, so the core never sees a partial divided-clock period.
- Debounces and synchronises the board reset button and counts button-initiated resets.

Parameters:
SYNC_STAGES, 2, flops in button synchroniser (≥2)
DEBOUNCE_CYCLES, 1024, consecutive stable cycles required to change debounced button state (≥1)
HOLD_CYCLES, 64, cycles both resets held after rst/button release (≥1)
DIV_SETTLE_CYCLES, 16, cycles between divRstN and coreRstN release (≥1, multiple of 4)
CNT_WIDTH, 16, width of internal counters (must hold max of the cycle parameters)
WATCHDOG_CYCLES, 65536, watchdog timeout (optional feature only)

Ports:
clk  input  1  fast clock (×4 of core clock)
rst  input  1  asynchronous, active-high reset (power-on / PLL not locked)
button  input  1  raw asynchronous reset button, active-high
wdKick  input  1  watchdog kick, synchronous to clk (optional feature only)
divRstN  output  1  active-low reset to clock divider
coreRstN  output  1  active-low reset to core
busy  output  1  high whenever state ≠ RUN
resetCount  output  8  saturating count of debounced button presses
wdFired  output  1  sticky watchdog timeout flag

Behaviour:
- rst high, asynchronously:
  - state=HOLD, all counters 0, synchroniser 0, debounced=0.
  - divRstN=0, coreRstN=0, busy=1, resetCount=0, wdFired=0.
- Synchroniser: button passes through SYNC_STAGES flops; last stage = btnSync.
- Debounce:
  - dbCnt increments each edge while btnSync ≠ debounced; clears on any edge where they are equal.
  - On the edge where dbCnt would reach DEBOUNCE_CYCLES, debounced ← btnSync and dbCnt ← 0.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
- FSM, all outputs registered:
  - HOLD: divRstN=0, coreRstN=0.
    - While debounced=1, holdCnt stays 0.
    - Otherwise holdCnt increments.
    - On the edge holdCnt reaches HOLD_CYCLES → DIV_RUN; divRstN←1 on that edge.
  - DIV_RUN: divRstN=1, coreRstN=0.
    - setCnt increments.
    - On the edge it reaches DIV_SETTLE_CYCLES → RUN; coreRstN←1 on that edge.
  - RUN: both 1; busy=0.
- Debounced 0→1 transition in any state:
  - Next edge: state←HOLD, counters←0, divRstN←0, coreRstN←0.
  - resetCount increments, saturating at 255.
  - Takes priority over any same-edge count completion.
- Debounced 1→0: no action other than unblocking holdCnt.
- busy is combinational from state, equal to !coreRstN.
- Latency from the first edge sampling button high to reset assertion: SYNC_STAGES+DEBOUNCE_CYCLES+1 edges.
- Counters never wrap; they stop at their terminal count by state change.
- Reset assertion via rst is asynchronous. All deassertions are synchronous to clk.

Optional Feature:
RESET_SEQ_WATCHDOG_EN
- Defined:
  - In RUN, wdCnt increments each edge; a wdKick=1 edge clears it.
  - On reaching WATCHDOG_CYCLES: wdFired←1 (sticky until rst), state←HOLD, both resets asserted next edge.
  - resetCount is not incremented.
  - wdCnt is held at 0 outside RUN.
- Not defined: wdKick ignored, wdFired tied 0, no watchdog logic synthesised.

Test Plan:
Bench parameters: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, DIV_SETTLE_CYCLES=16, WATCHDOG_CYCLES=32.
- rst high 3 cycles then low, button=0 → divRstN rises at edge 8, coreRstN at edge 24; busy falls with coreRstN; resetCount=0.
- In RUN, button high from edge k for 10 cycles → both resets low at edge k+7; resetCount=1; after button low and debounce, divRstN rises 8 edges later, coreRstN 16 after that.
- In RUN, 3-cycle button pulse → no output change, resetCount stays 0.
- 300 debounced presses → resetCount saturates at 255.
- rst asserted mid-DIV_RUN, between edges → divRstN/coreRstN/resetCount go 0 immediately without a clock edge; full sequence restarts after release.
- With RESET_SEQ_WATCHDOG_EN, no kick in RUN for 32 edges → wdFired=1, both resets low next edge, resetCount unchanged; kicking every 20 edges → wdFired stays 0.
